// File: rtl/vga_scan_ctrl.sv
// 640x480@60 Hz VGA scan controller: /4 pixel enable, h/v counters, registered colour and sync.
// Optional colour-bar generator is compiled in with `define VGA_TEST_PATTERN_EN.
module vga_scan_ctrl #(
   parameter int   H_VIS    = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_VIS    = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk_100mhz,
   input  logic       rst_n,
   input  logic [7:0] pix_data,
   input  logic       test_mode,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       pix_req,
   output logic       frame_start,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [1:0] blue,
   output logic       h_sync,
   output logic       v_sync
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
   localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

   logic [1:0] div;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       pix_tick;
   logic       h_wrap;
   logic       v_wrap;
   logic       in_hs;
   logic       in_vs;
   logic [7:0] colour;

   assign pix_tick = (div == 2'd3);
   assign h_wrap   = (h_cnt == H_LAST);
   assign v_wrap   = (v_cnt == V_LAST);
   assign in_hs    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign in_vs    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

   assign pix_x    = h_cnt;
   assign pix_y    = v_cnt;
   assign pix_req  = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar_k;

   // Eight 80-pixel bars; each bar index bit is replicated across its colour channel.
   always_comb begin
      bar_k = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (h_cnt >= 10'(i * 80)) begin
            bar_k = 3'(i);
         end
      end
      colour = test_mode ? {{3{bar_k[2]}}, {3{bar_k[1]}}, {2{bar_k[0]}}} : pix_data;
   end
`else
   logic unused_test_mode;

   assign unused_test_mode = test_mode;
   assign colour           = pix_data;
`endif

   // Outputs are sampled from the pre-increment counters so colour and sync stay aligned.
   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         div                 <= 2'd0;
         h_cnt               <= 10'd0;
         v_cnt               <= 10'd0;
         frame_start         <= 1'b0;
         {red, green, blue}  <= 8'h00;
         h_sync              <= ~SYNC_POL;
         v_sync              <= ~SYNC_POL;
      end else begin
         div         <= div + 2'd1;
         frame_start <= 1'b0;
         if (pix_tick) begin
            if (h_wrap) begin
               h_cnt       <= 10'd0;
               v_cnt       <= v_wrap ? 10'd0 : v_cnt + 10'd1;
               frame_start <= v_wrap;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
            {red, green, blue} <= pix_req ? colour : 8'h00;
            h_sync             <= in_hs ? SYNC_POL : ~SYNC_POL;
            v_sync             <= in_vs ? SYNC_POL : ~SYNC_POL;
         end
      end
   end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: full-size instance for line/data checks, shrunken instance for frame checks.
// Colour-bar checks follow VGA_TEST_PATTERN_EN when it is defined for the build.
module tb_vga_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_a;
   logic       rst_b;
   logic       test_mode_a;
   logic       force_ff;
   logic [7:0] pix_data_a;

   logic [9:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
   logic       pix_req_a, pix_req_b, frame_start_a, frame_start_b;
   logic [2:0] red_a, green_a, red_b, green_b;
   logic [1:0] blue_a, blue_b;
   logic       h_sync_a, v_sync_a, h_sync_b, v_sync_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign pix_data_a = force_ff ? 8'hFF : pix_x_a[7:0];

   vga_scan_ctrl dut_a (
      .clk_100mhz (clk),
      .rst_n      (rst_a),
      .pix_data   (pix_data_a),
      .test_mode  (test_mode_a),
      .pix_x      (pix_x_a),
      .pix_y      (pix_y_a),
      .pix_req    (pix_req_a),
      .frame_start(frame_start_a),
      .red        (red_a),
      .green      (green_a),
      .blue       (blue_a),
      .h_sync     (h_sync_a),
      .v_sync     (v_sync_a)
   );

   // Shrunken timing: 16 pixels x 12 lines, so a frame is 768 clocks.
   vga_scan_ctrl #(
      .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b0)
   ) dut_b (
      .clk_100mhz (clk),
      .rst_n      (rst_b),
      .pix_data   (8'hA5),
      .test_mode  (1'b0),
      .pix_x      (pix_x_b),
      .pix_y      (pix_y_b),
      .pix_req    (pix_req_b),
      .frame_start(frame_start_b),
      .red        (red_b),
      .green      (green_b),
      .blue       (blue_b),
      .h_sync     (h_sync_b),
      .v_sync     (v_sync_b)
   );

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
      end
   endtask

   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitA(input int x);
      int n = 0;
      while (pix_x_a != 10'(x) && n < 4000) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("wait_a_x", int'(pix_x_a), x);
   endtask

   task automatic waitB(input int x, input int y);
      int n = 0;
      while (!(pix_x_b == 10'(x) && pix_y_b == 10'(y)) && n < 2000) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("wait_b_xy", int'({pix_y_b, pix_x_b}), (y << 10) | x);
   endtask

   initial begin
      int n;
      int n2;
      rst_a       = 1'b0;
      rst_b       = 1'b0;
      test_mode_a = 1'b0;
      force_ff    = 1'b0;

      // Reset state of the full-size instance
      applyStimulus(10);
      checkOutput("rst_h_sync", int'(h_sync_a), 1);
      checkOutput("rst_v_sync", int'(v_sync_a), 1);
      checkOutput("rst_rgb", int'({red_a, green_a, blue_a}), 0);
      checkOutput("rst_pix_x", int'(pix_x_a), 0);
      checkOutput("rst_pix_y", int'(pix_y_a), 0);
      checkOutput("rst_frame_start", int'(frame_start_a), 0);

      rst_a = 1'b1;
      applyStimulus(3);
      checkOutput("pix_x_after_3", int'(pix_x_a), 0);
      applyStimulus(1);
      checkOutput("pix_x_after_4", int'(pix_x_a), 1);
      applyStimulus(4);
      checkOutput("pix_x_after_8", int'(pix_x_a), 2);

      // Data path and blanking on line 0
      waitA(5);
      applyStimulus(3);
      checkOutput("rgb_x4", int'({red_a, green_a, blue_a}), 8'h04);
      applyStimulus(1);
      checkOutput("rgb_x5", int'({red_a, green_a, blue_a}), 8'h05);

      waitA(600);
      checkOutput("req_x600", int'(pix_req_a), 1);
      force_ff = 1'b1;
      applyStimulus(4);
      checkOutput("rgb_x600_ff", int'({red_a, green_a, blue_a}), 8'hFF);
      force_ff = 1'b0;

      waitA(639);
      checkOutput("req_x639", int'(pix_req_a), 1);
      waitA(640);
      checkOutput("req_x640", int'(pix_req_a), 0);

      waitA(700);
      force_ff = 1'b1;
      applyStimulus(4);
      checkOutput("rgb_x700_blank", int'({red_a, green_a, blue_a}), 8'h00);
      force_ff = 1'b0;

      // Horizontal sync on line 1
      waitA(656);
      checkOutput("line1_pix_y", int'(pix_y_a), 1);
      checkOutput("hs_before_fall", int'(h_sync_a), 1);
      n = 0;
      while (h_sync_a !== 1'b0 && n < 20) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("hs_fall_delay", n, 4);
      n = 0;
      while (h_sync_a !== 1'b1 && n < 1000) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("hs_low_clocks", n, 384);
      n2 = 0;
      while (h_sync_a !== 1'b0 && n2 < 4000) begin
         applyStimulus(1);
         n2++;
      end
      checkOutput("line_period", n + n2, 3200);

      // Colour-bar source on the next line
      test_mode_a = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      force_ff = 1'b1;
      waitA(0);
      applyStimulus(4);
      checkOutput("bar_x0", int'({red_a, green_a, blue_a}), 8'h00);
      waitA(79);
      applyStimulus(4);
      checkOutput("bar_x79", int'({red_a, green_a, blue_a}), 8'h00);
      waitA(80);
      applyStimulus(4);
      checkOutput("bar_x80", int'({red_a, green_a, blue_a}), 8'h03);
      waitA(160);
      applyStimulus(4);
      checkOutput("bar_x160", int'({red_a, green_a, blue_a}), 8'h1C);
      waitA(560);
      applyStimulus(4);
      checkOutput("bar_x560", int'({red_a, green_a, blue_a}), 8'hFF);
      force_ff = 1'b0;
`else
      waitA(80);
      applyStimulus(4);
      checkOutput("nobar_x80", int'({red_a, green_a, blue_a}), 8'h50);
      waitA(560);
      applyStimulus(4);
      checkOutput("nobar_x560", int'({red_a, green_a, blue_a}), 8'h30);
`endif
      test_mode_a = 1'b0;

      // Frame timing on the shrunken instance
      applyStimulus(1);
      rst_b = 1'b0;
      applyStimulus(2);
      checkOutput("b_rst_frame_start", int'(frame_start_b), 0);
      checkOutput("b_rst_v_sync", int'(v_sync_b), 1);
      rst_b = 1'b1;
      n = 0;
      while (frame_start_b !== 1'b1 && n < 2000) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("b_first_frame_start", n, 768);
      checkOutput("b_wrap_xy", int'({pix_y_b, pix_x_b}), 0);
      applyStimulus(1);
      checkOutput("b_frame_start_width", int'(frame_start_b), 0);
      n = 1;
      while (frame_start_b !== 1'b1 && n < 2000) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("b_frame_period", n, 768);

      waitB(0, 8);
      checkOutput("b_vs_before_fall", int'(v_sync_b), 1);
      n = 0;
      while (v_sync_b !== 1'b0 && n < 20) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("b_vs_fall_delay", n, 4);
      n = 0;
      while (v_sync_b !== 1'b1 && n < 1000) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("b_vs_low_clocks", n, 128);

      // Mid-frame reset for a single clock
      waitB(5, 3);
      rst_b = 1'b0;
      applyStimulus(1);
      checkOutput("b_mid_rst_xy", int'({pix_y_b, pix_x_b}), 0);
      checkOutput("b_mid_rst_hs", int'(h_sync_b), 1);
      checkOutput("b_mid_rst_vs", int'(v_sync_b), 1);
      checkOutput("b_mid_rst_rgb", int'({red_b, green_b, blue_b}), 0);
      checkOutput("b_mid_rst_fs", int'(frame_start_b), 0);
      rst_b = 1'b1;
      applyStimulus(4);
      checkOutput("b_resume_x", int'(pix_x_b), 1);
      n = 4;
      while (frame_start_b !== 1'b1 && n < 2000) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("b_rst_to_frame_start", n, 768);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- 640x480@60 Hz VGA scan controller that drives the board's red/green/blue/h_sync/v_sync pins.
- Runs from the 100 MHz board clock with a /4 pixel enable (25 MHz pixel rate).
- Presents the current pixel coordinate to the upstream frame-buffer/display logic and accepts one 8-bit RGB332 pixel back per pixel period.
- Outputs are registered so that colour and sync leave the block aligned.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of h_sync/v_sync (0 = active-low)

Ports:
- clk_100mhz  in  1  system clock
- rst_n  in  1  reset; one clock domain, synchronous, active-low
- pix_data  in  8  RGB332 for the coordinate on pix_x/pix_y; [7:5]=R, [4:2]=G, [1:0]=B
- test_mode  in  1  select colour-bar source (see Optional Feature)
- pix_x  out  10  current horizontal count, 0..799
- pix_y  out  10  current vertical count, 0..524
- pix_req  out  1  high while (pix_x,pix_y) is inside the visible area
- frame_start  out  1  one-clock pulse when the counters wrap to (0,0)
- red  out  3  VGA red
- green  out  3  VGA green
- blue  out  2  VGA blue
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync

Behaviour:
- Totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
- Reset (rst_n low at a clock edge):
  - div = 0, h_cnt = 0, v_cnt = 0, frame_start = 0, red/green/blue = 0.
  - h_sync and v_sync are driven to the inactive level, ~SYNC_POL.
  - Reset asserted mid-line or mid-frame aborts immediately; scan restarts at (0,0) on the first edge after release.
- Pixel enable: 2-bit div increments every clock; pix_tick = (div == 3), one clock in four.
- Counters (update only on pix_tick):
  - h_cnt increments; at H_TOT-1 it wraps to 0 and v_cnt increments.
  - At (H_TOT-1, V_TOT-1) both wrap to 0 on the same edge, and frame_start is registered high for exactly one clock.
- Combinational from counter registers:
  - pix_x = h_cnt, pix_y = v_cnt.
  - pix_req = (h_cnt < H_VIS) && (v_cnt < V_VIS).
- Handshake with upstream:
  - A coordinate is held for 4 clocks.
  - pix_data must be valid at the pix_tick edge that ends that period; up to 3 clocks of read latency are allowed.
  - pix_data is ignored when pix_req is low.
- Output stage (registered on pix_tick, using pre-increment counter values):
  - {red,green,blue} <= pix_req ? pix_data : 8'h00.
  - h_sync <= SYNC_POL when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, else ~SYNC_POL.
  - v_sync <= SYNC_POL when V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC, else ~SYNC_POL.
  - Outputs therefore lag pix_x/pix_y by one pixel period (4 clocks). Colour and sync stay mutually aligned.
- Blanking: outside the visible area rgb is forced to 0 whatever pix_data holds.
- Outputs hold between ticks; no glitches. Frame period is 800*525*4 = 1,680,000 clocks.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined and test_mode = 1: the output stage ignores pix_data and emits 8 vertical colour bars, each 80 pixels wide. Bar index k = h_cnt[9:0]/80, 0..7; colour = {k[2],k[2],k[2], k[1],k[1],k[1], k[0],k[0]}. Blanking and sync behaviour are unchanged.
- When not defined: test_mode is left unconnected internally and pix_data is always used.

Test Plan:
- Reset/initial: hold rst_n=0 for 10 clocks -> h_sync=v_sync=1, rgb=0, pix_x=pix_y=0. Release -> pix_x=1 after 4 clocks, and pix_x steps every 4 clocks thereafter.
- Line timing: run one line -> h_sync low for exactly 96*4=384 clocks. Its falling edge is 4 clocks after pix_x reaches 656. Line period is 3200 clocks.
- Frame timing: run 2 frames -> v_sync low for 2 lines (6400 clocks) starting at line 490. frame_start pulses are exactly 1,680,000 clocks apart, each 1 clock wide.
- Data/blanking: drive pix_data = pix_x[7:0] -> at visible pixel x=5 the output rgb is 8'h05 one tick later. At x=700 the output is 0 even with pix_data=8'hFF.
- Mid-frame reset: assert rst_n=0 at line 200 for 1 clock -> the next edge shows (0,0), sync inactive, rgb 0, and normal timing resumes with no frame_start until the full frame completes.
- Test pattern (VGA_TEST_PATTERN_EN defined, test_mode=1): pixel 0 -> 8'h00; pixel 80 -> 8'h03; pixel 560 -> 8'hFF; pix_data is ignored.
